// File: rtl/touch_point_filter.sv
// Averages a batch of 2**SAMPLES_LOG2 raw touch samples; emits the mean only when every axis stays within SPREAD.
// Registered outputs: verdict pulses 2 edges after the last sample; no backpressure, samples arriving in CHECK are dropped.
module touch_point_filter #(
  parameter int          SAMPLES_LOG2 = 2,
  parameter logic [7:0]  SPREAD       = 8'd8,
  parameter logic [23:0] TIMEOUT      = 24'd5000000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        iDone,
  input  logic [15:0] iData,
  output logic        oDone,
  output logic [15:0] oData,
  output logic        oReject,
  output logic        oTimeout
);

  localparam int SUM_W = 8 + SAMPLES_LOG2;
  localparam int CNT_W = SAMPLES_LOG2 + 1;
  localparam int N     = 1 << SAMPLES_LOG2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  state_t             r_state;
  logic [SUM_W-1:0]   r_sum_x;
  logic [SUM_W-1:0]   r_sum_y;
  logic [7:0]         r_min_x;
  logic [7:0]         r_max_x;
  logic [7:0]         r_min_y;
  logic [7:0]         r_max_y;
  logic [CNT_W-1:0]   r_cnt;
  logic [23:0]        r_timer;
  logic               r_done;
  logic               r_reject;
  logic               r_timeout;
  logic [15:0]        r_data;

  state_t             w_state_nxt;
  logic [SUM_W-1:0]   w_sum_x_nxt;
  logic [SUM_W-1:0]   w_sum_y_nxt;
  logic [7:0]         w_min_x_nxt;
  logic [7:0]         w_max_x_nxt;
  logic [7:0]         w_min_y_nxt;
  logic [7:0]         w_max_y_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [23:0]        w_timer_nxt;
  logic               w_done_nxt;
  logic               w_reject_nxt;
  logic               w_timeout_nxt;
  logic [15:0]        w_data_nxt;

  logic [7:0]         w_x;
  logic [7:0]         w_y;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [7:0]         w_spread_x;
  logic [7:0]         w_spread_y;
  logic [7:0]         w_avg_x;
  logic [7:0]         w_avg_y;
  logic               w_spread_ok;

  assign w_x         = iData[15:8];
  assign w_y         = iData[7:0];
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_spread_x  = r_max_x - r_min_x;
  assign w_spread_y  = r_max_y - r_min_y;
  assign w_spread_ok = (w_spread_x <= SPREAD) && (w_spread_y <= SPREAD);
  // Sums carry SAMPLES_LOG2 extra bits, so the top 8 bits are the truncated mean.
  assign w_avg_x     = r_sum_x[SUM_W-1:SAMPLES_LOG2];
  assign w_avg_y     = r_sum_y[SUM_W-1:SAMPLES_LOG2];

  always_comb begin
    w_state_nxt   = r_state;
    w_sum_x_nxt   = r_sum_x;
    w_sum_y_nxt   = r_sum_y;
    w_min_x_nxt   = r_min_x;
    w_max_x_nxt   = r_max_x;
    w_min_y_nxt   = r_min_y;
    w_max_y_nxt   = r_max_y;
    w_cnt_nxt     = r_cnt;
    w_timer_nxt   = r_timer;
    w_done_nxt    = 1'b0;
    w_reject_nxt  = 1'b0;
    w_timeout_nxt = 1'b0;
    w_data_nxt    = r_data;

    case (r_state)
      S_IDLE: begin
        if (iDone) begin
          w_sum_x_nxt = SUM_W'(w_x);
          w_sum_y_nxt = SUM_W'(w_y);
          w_min_x_nxt = w_x;
          w_max_x_nxt = w_x;
          w_min_y_nxt = w_y;
          w_max_y_nxt = w_y;
          w_cnt_nxt   = CNT_W'(1);
          w_timer_nxt = 24'd0;
          w_state_nxt = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (iDone) begin
          w_sum_x_nxt = r_sum_x + SUM_W'(w_x);
          w_sum_y_nxt = r_sum_y + SUM_W'(w_y);
          w_min_x_nxt = (w_x < r_min_x) ? w_x : r_min_x;
          w_max_x_nxt = (w_x > r_max_x) ? w_x : r_max_x;
          w_min_y_nxt = (w_y < r_min_y) ? w_y : r_min_y;
          w_max_y_nxt = (w_y > r_max_y) ? w_y : r_max_y;
          w_cnt_nxt   = w_cnt_inc;
          w_timer_nxt = 24'd0;
          if (w_cnt_inc == CNT_W'(N)) begin
            w_state_nxt = S_CHECK;
          end
        end else if (r_timer == TIMEOUT - 24'd1) begin
          w_timeout_nxt = 1'b1;
          w_sum_x_nxt   = '0;
          w_sum_y_nxt   = '0;
          w_min_x_nxt   = 8'd0;
          w_max_x_nxt   = 8'd0;
          w_min_y_nxt   = 8'd0;
          w_max_y_nxt   = 8'd0;
          w_cnt_nxt     = '0;
          w_timer_nxt   = 24'd0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + 24'd1;
        end
      end

      S_CHECK: begin
        // A sample arriving in this cycle is intentionally ignored.
        if (w_spread_ok) begin
          w_done_nxt = 1'b1;
          w_data_nxt = {w_avg_x, w_avg_y};
        end else begin
          w_reject_nxt = 1'b1;
        end
        w_sum_x_nxt = '0;
        w_sum_y_nxt = '0;
        w_min_x_nxt = 8'd0;
        w_max_x_nxt = 8'd0;
        w_min_y_nxt = 8'd0;
        w_max_y_nxt = 8'd0;
        w_cnt_nxt   = '0;
        w_timer_nxt = 24'd0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_sum_x   <= '0;
      r_sum_y   <= '0;
      r_min_x   <= 8'd0;
      r_max_x   <= 8'd0;
      r_min_y   <= 8'd0;
      r_max_y   <= 8'd0;
      r_cnt     <= '0;
      r_timer   <= 24'd0;
      r_done    <= 1'b0;
      r_reject  <= 1'b0;
      r_timeout <= 1'b0;
      r_data    <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_sum_x   <= w_sum_x_nxt;
      r_sum_y   <= w_sum_y_nxt;
      r_min_x   <= w_min_x_nxt;
      r_max_x   <= w_max_x_nxt;
      r_min_y   <= w_min_y_nxt;
      r_max_y   <= w_max_y_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timer   <= w_timer_nxt;
      r_done    <= w_done_nxt;
      r_reject  <= w_reject_nxt;
      r_timeout <= w_timeout_nxt;
      r_data    <= w_data_nxt;
    end
  end

  assign oDone    = r_done;
  assign oReject  = r_reject;
  assign oTimeout = r_timeout;
  assign oData    = r_data;

endmodule

// File: tb/tb_touch_point_filter.sv
// Directed bench for touch_point_filter: a scoreboard queue holds the expected verdict,
// its cycle and its point; a negedge monitor pops and compares every output pulse.
module tb_touch_point_filter;

  localparam logic [23:0] T_OUT = 24'd20;
  localparam int K_DONE = 0;
  localparam int K_REJ  = 1;
  localparam int K_TO   = 2;

  typedef struct {
    int          kind;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        i_done;
  logic [15:0] i_data;
  logic        o_done;
  logic [15:0] o_data;
  logic        o_reject;
  logic        o_timeout;

  int          checks;
  int          failures;
  int          cyc;
  logic [15:0] model_data;
  exp_t        sb[$];

  touch_point_filter #(
    .SAMPLES_LOG2(2),
    .SPREAD      (8'd8),
    .TIMEOUT     (T_OUT)
  ) dut (
    .CLOCK   (clk),
    .RESET   (rst),
    .iDone   (i_done),
    .iData   (i_data),
    .oDone   (o_done),
    .oData   (o_data),
    .oReject (o_reject),
    .oTimeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs just after the active edge.
  task automatic tick(input logic r, input logic v, input logic [15:0] d);
    @(posedge clk);
    #1;
    rst    = r;
    i_done = v;
    i_data = d;
  endtask

  task automatic push(input int kind, input logic [15:0] d, input int at);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  // Four back-to-back samples; the verdict lands 2 edges after the last is sampled.
  task automatic batch4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [15:0] d, input int kind, input logic [15:0] exp_d);
    tick(1'b0, 1'b1, a);
    tick(1'b0, 1'b1, b);
    tick(1'b0, 1'b1, c);
    tick(1'b0, 1'b1, d);
    push(kind, exp_d, cyc + 2);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      tick(1'b0, 1'b0, 16'h0000);
    end
    tick(1'b0, 1'b0, 16'h0000);
    check(tag, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (o_done || o_reject || o_timeout) begin
      exp_t e;
      check("exclusive", 32'(o_done) + 32'(o_reject) + 32'(o_timeout), 1);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, o_timeout, o_reject, o_done}, 0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {29'd0, o_timeout, o_reject, o_done}, 32'(1) << e.kind);
        check("pulse_cycle", cyc, e.cyc);
        if (e.kind == K_DONE) model_data = e.data;
        check("odata", o_data, model_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    model_data = 16'h0000;
    rst        = 1'b1;
    i_done     = 1'b0;
    i_data     = 16'h0000;
    tick(1'b1, 1'b0, 16'h0000);
    tick(1'b1, 1'b1, 16'h1234);
    tick(1'b0, 1'b0, 16'h0000);
    check("rst_odone", o_done, 0);
    check("rst_oreject", o_reject, 0);
    check("rst_otimeout", o_timeout, 0);
    check("rst_odata", o_data, 16'h0000);

    // 1: identical samples back to back
    batch4(16'h4080, 16'h4080, 16'h4080, 16'h4080, K_DONE, 16'h4080);
    drain("t1_drain");

    // 2: spaced samples, truncating mean, and all-ones edge case
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, {8'(10 + i), 8'd200});
      if (i == 3) push(K_DONE, 16'h0BC8, cyc + 2);
      for (int j = 0; j < 6; j++) tick(1'b0, 1'b0, 16'h0000);
    end
    drain("t2_drain");
    batch4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, K_DONE, 16'hFFFF);
    drain("t2_ff_drain");

    // 3: spread exactly SPREAD passes, SPREAD+1 rejects on either axis
    batch4(16'h0AC8, 16'h0AC8, 16'h0AC8, 16'h12C8, K_DONE, 16'h0CC8);
    drain("t3_pass_drain");
    batch4(16'h0AC8, 16'h0AC8, 16'h0AC8, 16'h13C8, K_REJ, 16'h0000);
    drain("t3_rejx_drain");
    check("t3_odata_kept", o_data, 16'h0CC8);
    batch4(16'h0500, 16'h0500, 16'h0500, 16'h0509, K_REJ, 16'h0000);
    drain("t3_rejy_drain");

    // 4: partial batch then silence
    tick(1'b0, 1'b1, 16'h7777);
    tick(1'b0, 1'b1, 16'h7777);
    push(K_TO, 16'h0000, cyc + 1 + int'(T_OUT));
    for (int j = 0; j < 25; j++) tick(1'b0, 1'b0, 16'h0000);
    drain("t4_to_drain");
    batch4(16'h2030, 16'h2030, 16'h2030, 16'h2030, K_DONE, 16'h2030);
    drain("t4_after_drain");

    // 5: reset mid-batch, with a sample in the reset cycle
    tick(1'b0, 1'b1, 16'h5050);
    tick(1'b0, 1'b1, 16'h5050);
    tick(1'b0, 1'b1, 16'h5050);
    tick(1'b1, 1'b1, 16'hFFFF);
    tick(1'b0, 1'b0, 16'h0000);
    model_data = 16'h0000;
    check("t5_rst_odone", o_done, 0);
    check("t5_rst_odata", o_data, 16'h0000);
    batch4(16'h1010, 16'h1012, 16'h1014, 16'h1016, K_DONE, 16'h1013);
    drain("t5_drain");

    // 6: sample during CHECK is dropped; next four form their own batch
    batch4(16'h3030, 16'h3030, 16'h3030, 16'h3030, K_DONE, 16'h3030);
    tick(1'b0, 1'b1, 16'hF0F0);
    tick(1'b0, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 16'h0000);
    batch4(16'h3234, 16'h3234, 16'h3234, 16'h3234, K_DONE, 16'h3234);
    drain("t6_drain");
    for (int j = 0; j < 30; j++) tick(1'b0, 1'b0, 16'h0000);
    check("final_odata", o_data, 16'h3234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
